// File: rtl/f1_pkg.sv
// f1_pkg: shared types and constants for the F1 random hold-off stage.
package f1_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, COUNT, DONE} delay_state_t;
  localparam int LFSR_W = 16;
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;
  localparam logic [LFSR_W-1:0] DEFAULT_SEED = 16'hACE1;
endpackage

// File: rtl/f1_lfsr16.sv
// f1_lfsr16: enabled 16-bit Fibonacci LFSR with all-zero lock-up recovery.
module f1_lfsr16
  import f1_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = DEFAULT_SEED
) (
  input  logic              sysclk,
  input  logic              rst_n,
  input  logic              en,
  output logic [LFSR_W-1:0] q
);
  logic [LFSR_W-1:0] q_q, q_d;
  always_comb q_d = (q_q == '0) ? SEED : en ? {q_q[LFSR_W-2:0], ^(q_q & LFSR_TAPS)} : q_q;
  always_ff @(posedge sysclk or negedge rst_n)
    if (!rst_n) q_q <= SEED;
    else q_q <= q_d;
  assign q = q_q;
endmodule

// File: rtl/f1_random_delay.sv
// f1_random_delay: captures MIN_MS plus random LFSR bits on start, counts it down
// on 1 ms ticks and returns a single-cycle time_out ("lights out").
module f1_random_delay
  import f1_pkg::*;
#(
  parameter int                MIN_MS    = 250,
  parameter int                RAND_BITS = 12,
  parameter int                DELAY_W   = 13,
  parameter logic [LFSR_W-1:0] SEED      = DEFAULT_SEED
) (
  input  logic               sysclk,
  input  logic               rst_n,
  input  logic               tick,
  input  logic               en_lfsr,
  input  logic               start_delay,
  output logic               time_out,
  output logic               busy,
  output logic [DELAY_W-1:0] delay_ms,
  output logic [LFSR_W-1:0]  lfsr_q
);
  if (longint'(MIN_MS) + (longint'(1) << RAND_BITS) - 1 >= (longint'(1) << DELAY_W)) begin : g_bad_width
    $error("DELAY_W cannot hold MIN_MS + 2**RAND_BITS - 1");
  end
  if (SEED == '0) begin : g_bad_seed
    $error("SEED must be nonzero");
  end
  delay_state_t state_q, state_d;
  logic [DELAY_W-1:0] count_q, count_d, delay_q, delay_d, load_val;
  logic time_out_q, time_out_d, busy_q, busy_d;
  f1_lfsr16 #(.SEED(SEED)) u_lfsr (
    .sysclk(sysclk),
    .rst_n (rst_n),
    .en    (en_lfsr),
    .q     (lfsr_q)
  );
  assign load_val = DELAY_W'(MIN_MS) + DELAY_W'(lfsr_q[RAND_BITS-1:0]);
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    delay_d = delay_q;
    case (state_q)
      IDLE: state_d = start_delay ? LOAD : IDLE;
      LOAD: begin
        state_d = COUNT;
        count_d = load_val;
        delay_d = load_val;
      end
      COUNT: begin
        state_d = (count_q == '0) ? DONE : COUNT;
        count_d = (tick && count_q != '0) ? count_q - DELAY_W'(1) : count_q;
      end
      default: state_d = IDLE;
    endcase
    // outputs registered from the next state so time_out aligns with DONE
    time_out_d = (state_d == DONE);
    busy_d     = (state_d != IDLE);
  end
  always_ff @(posedge sysclk or negedge rst_n)
    if (!rst_n) begin
      state_q    <= IDLE;
      count_q    <= '0;
      delay_q    <= '0;
      time_out_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      delay_q    <= delay_d;
      time_out_q <= time_out_d;
      busy_q     <= busy_d;
    end
  assign time_out = time_out_q;
  assign busy     = busy_q;
  assign delay_ms = delay_q;
endmodule

// File: tb/tb_f1_random_delay.sv
// tb_f1_random_delay: directed stimulus on three parameterisations with a
// time_out scoreboard checked by a decoupled monitor thread.
module tb_f1_random_delay;
  typedef struct {int inst; int cyc; int dly;} exp_t;
  logic sysclk = 1'b0;
  logic rst_n = 1'b0;
  logic [2:0] tick = '0, en = '0, start = '0;
  wire  [2:0] to, busy;
  wire  [12:0] dly0;
  wire  [2:0]  dly1;
  wire  [1:0]  dly2;
  wire  [15:0] lq0, lq1, lq2;
  wire  [12:0] dm [3];
  exp_t sb[$];
  int cyc = 0;
  int n_chk = 0, n_pass = 0;
  int idx;
  assign dm[0] = dly0;
  assign dm[1] = {10'd0, dly1};
  assign dm[2] = {11'd0, dly2};
  always #5 sysclk = ~sysclk;
  always @(posedge sysclk) cyc <= cyc + 1;
  f1_random_delay dut0 (
    .sysclk(sysclk), .rst_n(rst_n), .tick(tick[0]), .en_lfsr(en[0]), .start_delay(start[0]),
    .time_out(to[0]), .busy(busy[0]), .delay_ms(dly0), .lfsr_q(lq0)
  );
  f1_random_delay #(.MIN_MS(2), .RAND_BITS(2), .DELAY_W(3)) dut1 (
    .sysclk(sysclk), .rst_n(rst_n), .tick(tick[1]), .en_lfsr(en[1]), .start_delay(start[1]),
    .time_out(to[1]), .busy(busy[1]), .delay_ms(dly1), .lfsr_q(lq1)
  );
  f1_random_delay #(.MIN_MS(0), .RAND_BITS(2), .DELAY_W(2)) dut2 (
    .sysclk(sysclk), .rst_n(rst_n), .tick(tick[2]), .en_lfsr(en[2]), .start_delay(start[2]),
    .time_out(to[2]), .busy(busy[2]), .delay_ms(dly2), .lfsr_q(lq2)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else n_pass++;
  endtask
  task automatic step();
    @(posedge sysclk);
    #1;
  endtask
  // start on instance i, then feed exactly dly ticks spaced per cycles
  task automatic run(input int i, input int dly, input int per, input bit mid);
    int p;
    p = cyc;
    start[i] = 1'b1;
    sb.push_back('{i, (dly == 0) ? p + 3 : p + 4 + (dly - 1) * per, dly});
    step();
    start[i] = 1'b0;
    chk("busy_after_start", 32'(busy[i]), 1);
    step();
    chk("delay_ms_loaded", 32'(dm[i]), dly);
    for (int k = 0; k < dly; k++) begin
      tick[i] = 1'b1;
      step();
      tick[i] = 1'b0;
      if (mid && k == 0) begin
        start[i] = 1'b1;
        step();
        start[i] = 1'b0;
        repeat (per - 2) step();
      end else repeat (per - 1) step();
    end
    repeat (4) step();
    chk("busy_back_idle", 32'(busy[i]), 0);
    chk("delay_ms_hold", 32'(dm[i]), dly);
  endtask
  initial begin
    fork
      forever begin
        @(negedge sysclk);
        for (int i = 0; i < 3; i++)
          if (to[i]) begin
            idx = -1;
            foreach (sb[j]) if (idx < 0 && sb[j].inst == i) idx = j;
            if (idx < 0) chk($sformatf("unexpected_time_out%0d", i), 32'(cyc), 0);
            else begin
              chk($sformatf("time_out_cycle%0d", i), 32'(cyc), 32'(sb[idx].cyc));
              chk($sformatf("delay_at_time_out%0d", i), 32'(dm[i]), 32'(sb[idx].dly));
              sb.delete(idx);
            end
          end
      end
    join_none
    step();
    step();
    chk("rst_lfsr", 32'(lq0), 32'h0000ACE1);
    chk("rst_delay", 32'(dly0), 0);
    chk("rst_time_out", 32'(to[0]), 0);
    chk("rst_busy", 32'(busy[0]), 0);
    rst_n = 1'b1;
    step();
    en[0] = 1'b1;
    step();
    en[0] = 1'b0;
    chk("lfsr_step1", 32'(lq0), 32'h000059C3);
    repeat (5) step();
    chk("lfsr_hold", 32'(lq0), 32'h000059C3);
    run(0, 2749, 2, 1'b0);
    chk("lfsr_hold_after_run", 32'(lq0), 32'h000059C3);
    run(1, 3, 10, 1'b0);
    en[2] = 1'b1;
    repeat (5) step();
    en[2] = 1'b0;
    chk("lfsr_step5", 32'(lq2), 32'h00009C3C);
    run(2, 0, 1, 1'b0);
    run(1, 3, 10, 1'b1);
    start[0] = 1'b1;
    step();
    start[0] = 1'b0;
    step();
    repeat (5) begin
      tick[0] = 1'b1;
      step();
      tick[0] = 1'b0;
      step();
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy[0]), 0);
    chk("abort_time_out", 32'(to[0]), 0);
    chk("abort_lfsr", 32'(lq0), 32'h0000ACE1);
    chk("abort_delay", 32'(dly0), 0);
    step();
    rst_n = 1'b1;
    repeat (3) step();
    force dut0.u_lfsr.q_q = 16'h0000;
    en[0] = 1'b1;
    #1;
    release dut0.u_lfsr.q_q;
    step();
    en[0] = 1'b0;
    chk("lockup_recover", 32'(lq0), 32'h0000ACE1);
    en[2] = 1'b1;
    repeat (5) step();
    en[2] = 1'b0;
    idx = cyc;
    start[2] = 1'b1;
    sb.push_back('{2, idx + 3, 0});
    sb.push_back('{2, idx + 7, 0});
    repeat (4) step();
    chk("b2b_idle_gap", 32'(busy[2]), 0);
    step();
    start[2] = 1'b0;
    chk("b2b_reload_busy", 32'(busy[2]), 1);
    repeat (6) step();
    chk("b2b_done_idle", 32'(busy[2]), 0);
    repeat (3) step();
    foreach (sb[j]) chk($sformatf("missing_time_out%0d", sb[j].inst), 0, 32'(sb[j].cyc));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
